// File: rtl/plus_pkg.sv
// Shared types, constants and helpers for the Plus colour stage.
// Colours are held as {G,R,B} nibbles, the order the palette RAM stores them.
package plus_pkg;

    localparam int         PAL_ENTRIES  = 17;
    localparam logic [4:0] BORDER_ENTRY = 5'd16;

    typedef struct packed {
        logic [3:0] g;
        logic [3:0] r;
        logic [3:0] b;
    } rgb12_t;

    // Gate Array hardware colour number -> {G,R,B} using the 0/6/F levels.
    localparam rgb12_t HW2RGB [32] = '{
        12'h666, 12'h666, 12'hF06, 12'hFF6, 12'h006, 12'h0F6, 12'h606, 12'h6F6,
        12'h0F6, 12'hFF6, 12'hFF0, 12'hFFF, 12'h0F0, 12'h0FF, 12'h6F0, 12'h6FF,
        12'h006, 12'hF06, 12'hF00, 12'hF0F, 12'h000, 12'h00F, 12'h600, 12'h60F,
        12'h066, 12'hF66, 12'hF60, 12'hF6F, 12'h060, 12'h06F, 12'h660, 12'h66F
    };

    // A tri-stated legacy pin sits at the half level.
    function automatic logic [3:0] legacy_level(input logic       pin,
                                                input logic       oe_n,
                                                input logic [3:0] mid);
        logic [3:0] lvl;
        if (oe_n) lvl = mid;
        else      lvl = pin ? 4'hF : 4'h0;
        return lvl;
    endfunction

endpackage

// File: rtl/plus_pal_ram.sv
// 17 x 12-bit palette register file: one byte-lane write port, a pixel read
// port and a CPU read port, both combinational. Out-of-range entries read 0.
module plus_pal_ram
    import plus_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_wr_en,
    input  logic [4:0] i_wr_entry,
    input  logic [1:0] i_wr_mask,
    input  rgb12_t     i_wr_data,
    input  logic [4:0] i_pix_entry,
    output rgb12_t     o_pix_data,
    input  logic [4:0] i_cpu_entry,
    output rgb12_t     o_cpu_data
);

    rgb12_t r_mem [PAL_ENTRIES];

    // Mask bit 0 covers the {R,B} byte, bit 1 the G nibble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PAL_ENTRIES; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en && (i_wr_entry <= BORDER_ENTRY)) begin
            if (i_wr_mask[0]) begin
                r_mem[i_wr_entry].r <= i_wr_data.r;
                r_mem[i_wr_entry].b <= i_wr_data.b;
            end
            if (i_wr_mask[1]) begin
                r_mem[i_wr_entry].g <= i_wr_data.g;
            end
        end
    end

    assign o_pix_data = (i_pix_entry <= BORDER_ENTRY) ? r_mem[i_pix_entry] : '0;
    assign o_cpu_data = (i_cpu_entry <= BORDER_ENTRY) ? r_mem[i_cpu_entry] : '0;

endmodule

// File: rtl/plus_palette.sv
// Plus-ASIC colour stage: palette write arbitration (CPU vs ink mirror),
// CPU read register and the two-tick pixel pipeline to 12-bit RGB.
module plus_palette
    import plus_pkg::*;
#(
    parameter logic [3:0] MID_LEVEL = 4'h6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cen_16,
    input  logic       PLUS_EN,
    input  logic [3:0] PEN_ID,
    input  logic       BORDER_SEL,
    input  logic       BLANK,
    input  logic       RED,
    input  logic       RED_OE_N,
    input  logic       GREEN,
    input  logic       GREEN_OE_N,
    input  logic       BLUE,
    input  logic       BLUE_OE_N,
    input  logic       REG_WR,
    input  logic       REG_RD,
    input  logic [5:0] REG_ADDR,
    input  logic [7:0] REG_DATA,
    output logic [7:0] REG_Q,
    input  logic       INK_WR,
    input  logic [4:0] INK_IDX,
    input  logic [4:0] INK_HW,
    output logic [3:0] R_OUT,
    output logic [3:0] G_OUT,
    output logic [3:0] B_OUT
);

    logic       w_ink_ok;
    logic       w_wr_en;
    logic [4:0] w_wr_entry;
    logic [1:0] w_wr_mask;
    rgb12_t     w_wr_data;
    rgb12_t     w_pix_ram;
    rgb12_t     w_cpu_ram;
    rgb12_t     w_legacy;
    rgb12_t     w_pix;
    logic [4:0] w_pix_entry;

    logic       r_pend_vld;
    logic [4:0] r_pend_entry;
    rgb12_t     r_pend_data;
    logic [7:0] r_q;
    logic [3:0] r_pen;
    logic       r_border;
    logic       r_blank;
    logic       r_plus;
    rgb12_t     r_out;

    assign w_ink_ok = INK_WR && (INK_IDX <= BORDER_ENTRY);

    // CPU writes win; a colliding ink write waits in the pending slot, and a
    // fresh ink write supersedes whatever is pending.
    always_comb begin
        w_wr_en    = 1'b0;
        w_wr_entry = 5'd0;
        w_wr_mask  = 2'b00;
        w_wr_data  = '0;
        if (REG_WR) begin
            w_wr_en     = 1'b1;
            w_wr_entry  = REG_ADDR[5:1];
            w_wr_mask   = REG_ADDR[0] ? 2'b10 : 2'b01;
            w_wr_data.g = REG_DATA[3:0];
            w_wr_data.r = REG_DATA[7:4];
            w_wr_data.b = REG_DATA[3:0];
        end else if (w_ink_ok) begin
            w_wr_en    = 1'b1;
            w_wr_entry = INK_IDX;
            w_wr_mask  = 2'b11;
            w_wr_data  = HW2RGB[INK_HW];
        end else if (r_pend_vld) begin
            w_wr_en    = 1'b1;
            w_wr_entry = r_pend_entry;
            w_wr_mask  = 2'b11;
            w_wr_data  = r_pend_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_vld   <= 1'b0;
            r_pend_entry <= 5'd0;
            r_pend_data  <= '0;
        end else if (REG_WR) begin
            if (w_ink_ok) begin
                r_pend_vld   <= 1'b1;
                r_pend_entry <= INK_IDX;
                r_pend_data  <= HW2RGB[INK_HW];
            end
        end else begin
            r_pend_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= 8'h00;
        end else if (REG_RD) begin
            r_q <= REG_ADDR[0] ? {4'h0, w_cpu_ram.g} : {w_cpu_ram.r, w_cpu_ram.b};
        end
    end

    assign REG_Q = r_q;

    plus_pal_ram u_ram (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_wr_en     (w_wr_en),
        .i_wr_entry  (w_wr_entry),
        .i_wr_mask   (w_wr_mask),
        .i_wr_data   (w_wr_data),
        .i_pix_entry (w_pix_entry),
        .o_pix_data  (w_pix_ram),
        .i_cpu_entry (REG_ADDR[5:1]),
        .o_cpu_data  (w_cpu_ram)
    );

    // Legacy pins arrive one tick late upstream, so they are used unregistered.
    always_comb begin
        w_legacy.g  = legacy_level(GREEN, GREEN_OE_N, MID_LEVEL);
        w_legacy.r  = legacy_level(RED, RED_OE_N, MID_LEVEL);
        w_legacy.b  = legacy_level(BLUE, BLUE_OE_N, MID_LEVEL);
        w_pix_entry = r_border ? BORDER_ENTRY : {1'b0, r_pen};
        if (r_blank)      w_pix = '0;
        else if (!r_plus) w_pix = w_legacy;
        else              w_pix = w_pix_ram;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pen    <= 4'd0;
            r_border <= 1'b0;
            r_blank  <= 1'b0;
            r_plus   <= 1'b0;
            r_out    <= '0;
        end else if (cen_16) begin
            r_pen    <= PEN_ID;
            r_border <= BORDER_SEL;
            r_blank  <= BLANK;
            r_plus   <= PLUS_EN;
            r_out    <= w_pix;
        end
    end

    assign R_OUT = r_out.r;
    assign G_OUT = r_out.g;
    assign B_OUT = r_out.b;

endmodule

// File: tb/tb_plus_palette.sv
// Randomised and directed bench for plus_palette, checked cycle by cycle
// against a behavioural model of the palette, write priority and pixel timing.
module tb_plus_palette;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       cen_16 = 1'b0;
    logic       PLUS_EN = 1'b0;
    logic [3:0] PEN_ID = '0;
    logic       BORDER_SEL = 1'b0;
    logic       BLANK = 1'b0;
    logic       RED = 1'b0, RED_OE_N = 1'b0;
    logic       GREEN = 1'b0, GREEN_OE_N = 1'b0;
    logic       BLUE = 1'b0, BLUE_OE_N = 1'b0;
    logic       REG_WR = 1'b0, REG_RD = 1'b0;
    logic [5:0] REG_ADDR = '0;
    logic [7:0] REG_DATA = '0;
    logic [7:0] REG_Q;
    logic       INK_WR = 1'b0;
    logic [4:0] INK_IDX = '0;
    logic [4:0] INK_HW = '0;
    logic [3:0] R_OUT, G_OUT, B_OUT;

    int n_checks = 0;
    int n_errors = 0;

    plus_palette dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cen_16     (cen_16),
        .PLUS_EN    (PLUS_EN),
        .PEN_ID     (PEN_ID),
        .BORDER_SEL (BORDER_SEL),
        .BLANK      (BLANK),
        .RED        (RED),
        .RED_OE_N   (RED_OE_N),
        .GREEN      (GREEN),
        .GREEN_OE_N (GREEN_OE_N),
        .BLUE       (BLUE),
        .BLUE_OE_N  (BLUE_OE_N),
        .REG_WR     (REG_WR),
        .REG_RD     (REG_RD),
        .REG_ADDR   (REG_ADDR),
        .REG_DATA   (REG_DATA),
        .REG_Q      (REG_Q),
        .INK_WR     (INK_WR),
        .INK_IDX    (INK_IDX),
        .INK_HW     (INK_HW),
        .R_OUT      (R_OUT),
        .G_OUT      (G_OUT),
        .B_OUT      (B_OUT)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Hardware colours as decimal digits R,G,B with levels 0=off 1=half 2=full.
    int hw_lvl [32] = '{
        111, 111, 21, 221, 1, 201, 11, 211, 201, 221, 220, 222, 200, 202, 210, 212,
        1, 21, 20, 22, 0, 2, 10, 12, 101, 121, 120, 122, 100, 102, 110, 112
    };

    logic [11:0] m_pal [17];   // {R,G,B}
    logic [11:0] m_out;        // {R,G,B}
    logic [7:0]  m_q;
    logic [3:0]  m_pen;
    logic        m_border, m_blank, m_plus;
    logic        m_pv;
    int          m_pe;
    logic [4:0]  m_ph;

    function automatic logic [3:0] lvl_nib(input int l);
        return (l == 0) ? 4'h0 : (l == 1) ? 4'h6 : 4'hF;
    endfunction

    function automatic logic [11:0] hw_color(input logic [4:0] hw);
        int v;
        v = hw_lvl[hw];
        return {lvl_nib(v / 100), lvl_nib((v / 10) % 10), lvl_nib(v % 10)};
    endfunction

    function automatic logic [3:0] pin_level(input logic pin, input logic oe_n);
        if (oe_n) return 4'h6;
        return pin ? 4'hF : 4'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 17; i++) m_pal[i] = 12'h000;
        m_out = 12'h000; m_q = 8'h00; m_pen = 4'h0;
        m_border = 1'b0; m_blank = 1'b0; m_plus = 1'b0;
        m_pv = 1'b0; m_pe = 0; m_ph = 5'd0;
    endtask

    // Applies one clock edge's worth of behaviour using the inputs being driven.
    task automatic model_edge();
        int  e;
        bit  ink_ok;
        if (cen_16) begin
            if (m_blank)     m_out = 12'h000;
            else if (!m_plus) m_out = {pin_level(RED, RED_OE_N), pin_level(GREEN, GREEN_OE_N),
                                       pin_level(BLUE, BLUE_OE_N)};
            else             m_out = m_pal[m_border ? 16 : int'(m_pen)];
            m_pen = PEN_ID; m_border = BORDER_SEL; m_blank = BLANK; m_plus = PLUS_EN;
        end
        if (REG_RD) begin
            e = int'(REG_ADDR) / 2;
            if (e > 16)          m_q = 8'h00;
            else if (REG_ADDR[0]) m_q = {4'h0, m_pal[e][7:4]};
            else                 m_q = {m_pal[e][11:8], m_pal[e][3:0]};
        end
        ink_ok = INK_WR && (INK_IDX <= 5'd16);
        if (REG_WR) begin
            e = int'(REG_ADDR) / 2;
            if (e <= 16) begin
                if (REG_ADDR[0]) begin
                    m_pal[e][7:4] = REG_DATA[3:0];
                end else begin
                    m_pal[e][11:8] = REG_DATA[7:4];
                    m_pal[e][3:0]  = REG_DATA[3:0];
                end
            end
            if (ink_ok) begin
                m_pv = 1'b1; m_pe = int'(INK_IDX); m_ph = INK_HW;
            end
        end else if (ink_ok) begin
            m_pal[INK_IDX] = hw_color(INK_HW);
            m_pv = 1'b0;
        end else if (m_pv) begin
            m_pal[m_pe] = hw_color(m_ph);
            m_pv = 1'b0;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %03h expected %03h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("pixel", {R_OUT, G_OUT, B_OUT}, m_out);
        check_eq("reg_q", {4'h0, REG_Q}, {4'h0, m_q});
    endtask

    task automatic set_idle();
        cen_16 = 1'b1; PLUS_EN = 1'b1; BLANK = 1'b0; BORDER_SEL = 1'b0; PEN_ID = 4'h0;
        RED = 1'b0; RED_OE_N = 1'b0; GREEN = 1'b0; GREEN_OE_N = 1'b0;
        BLUE = 1'b0; BLUE_OE_N = 1'b0;
        REG_WR = 1'b0; REG_RD = 1'b0; INK_WR = 1'b0;
    endtask

    task automatic rand_inputs();
        cen_16     = ($urandom_range(0, 3) != 0);
        PLUS_EN    = ($urandom_range(0, 3) != 0);
        PEN_ID     = 4'($urandom_range(0, 15));
        BORDER_SEL = ($urandom_range(0, 3) == 0);
        BLANK      = ($urandom_range(0, 7) == 0);
        {RED, RED_OE_N, GREEN, GREEN_OE_N, BLUE, BLUE_OE_N} = 6'($urandom_range(0, 63));
        REG_WR     = ($urandom_range(0, 3) == 0);
        REG_RD     = ($urandom_range(0, 2) == 0);
        REG_ADDR   = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(34, 63))
                                                 : 6'($urandom_range(0, 33));
        REG_DATA   = 8'($urandom_range(0, 255));
        INK_WR     = ($urandom_range(0, 3) == 0);
        INK_IDX    = 5'($urandom_range(0, 20));
        INK_HW     = 5'($urandom_range(0, 31));
    endtask

    task automatic cpu_write(input logic [5:0] a, input logic [7:0] d);
        REG_WR = 1'b1; REG_ADDR = a; REG_DATA = d;
        step();
        REG_WR = 1'b0;
    endtask

    task automatic cpu_read(input logic [5:0] a);
        REG_RD = 1'b1; REG_ADDR = a;
        step();
        REG_RD = 1'b0;
    endtask

    task automatic async_reset();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_pixel", {R_OUT, G_OUT, B_OUT}, 12'h000);
        check_eq("rst_reg_q", {4'h0, REG_Q}, 12'h000);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        model_reset();
        #1 reset_n = 1'b0;
        #1;
        check_eq("por_pixel", {R_OUT, G_OUT, B_OUT}, 12'h000);
        check_eq("por_reg_q", {4'h0, REG_Q}, 12'h000);
        @(negedge clk);
        reset_n = 1'b1;

        // random traffic, then a reset mid-stream and a full read sweep
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            step();
        end
        async_reset();
        set_idle();
        for (int a = 0; a <= 8'h21; a++) begin
            cpu_read(6'(a));
            check_eq("sweep", {4'h0, REG_Q}, 12'h000);
        end

        // CPU write of entry 3, then a pen 3 pixel
        cpu_write(6'h06, 8'h5A);
        cpu_write(6'h07, 8'hC3);
        PEN_ID = 4'd3;
        step();
        step();
        check_eq("pen3_pixel", {R_OUT, G_OUT, B_OUT}, 12'h53A);
        cpu_read(6'h07);
        check_eq("pen3_g_byte", {4'h0, REG_Q}, 12'h003);
        cpu_read(6'h06);
        check_eq("pen3_rb_byte", {4'h0, REG_Q}, 12'h05A);

        // ink mirror into the border entry; out-of-range index ignored
        INK_WR = 1'b1; INK_IDX = 5'd16; INK_HW = 5'h0B;
        step();
        INK_WR = 1'b0; BORDER_SEL = 1'b1;
        step();
        step();
        check_eq("border_ink", {R_OUT, G_OUT, B_OUT}, 12'hFFF);
        INK_WR = 1'b1; INK_IDX = 5'd20; INK_HW = 5'h14;
        step();
        INK_WR = 1'b0;
        step();
        check_eq("ink_idx20_border", {R_OUT, G_OUT, B_OUT}, 12'hFFF);
        BORDER_SEL = 1'b0;
        step();
        check_eq("switch_lag", {R_OUT, G_OUT, B_OUT}, 12'hFFF);
        step();
        check_eq("switch_pen", {R_OUT, G_OUT, B_OUT}, 12'h53A);

        // CPU/ink collision: the ink write lands one cycle later
        REG_WR = 1'b1; REG_ADDR = 6'h02; REG_DATA = 8'hF0;
        INK_WR = 1'b1; INK_IDX = 5'd1; INK_HW = 5'h14;
        step();
        REG_WR = 1'b0; INK_WR = 1'b0;
        cpu_read(6'h02);
        check_eq("coll_cpu_first", {4'h0, REG_Q}, 12'h0F0);
        cpu_read(6'h02);
        check_eq("coll_ink_after", {4'h0, REG_Q}, 12'h000);

        // a CPU write in the next cycle delays the pending write again
        REG_WR = 1'b1; REG_ADDR = 6'h02; REG_DATA = 8'hF0;
        INK_WR = 1'b1; INK_IDX = 5'd1; INK_HW = 5'h0B;
        step();
        INK_WR = 1'b0; REG_ADDR = 6'h02; REG_DATA = 8'h11;
        REG_ADDR = 6'h3E;
        step();
        REG_WR = 1'b0;
        cpu_read(6'h02);
        check_eq("coll_delayed", {4'h0, REG_Q}, 12'h0F0);
        cpu_read(6'h02);
        check_eq("coll_landed_rb", {4'h0, REG_Q}, 12'h0FF);
        cpu_read(6'h03);
        check_eq("coll_landed_g", {4'h0, REG_Q}, 12'h00F);

        // legacy pin path
        PLUS_EN = 1'b0;
        step();
        RED_OE_N = 1'b1; GREEN = 1'b1; GREEN_OE_N = 1'b0; BLUE = 1'b0; BLUE_OE_N = 1'b0;
        step();
        check_eq("legacy_6f0", {R_OUT, G_OUT, B_OUT}, 12'h6F0);

        // blanking in both modes
        BLANK = 1'b1; PLUS_EN = 1'b1; PEN_ID = 4'd3;
        step();
        step();
        check_eq("blank_plus", {R_OUT, G_OUT, B_OUT}, 12'h000);
        PLUS_EN = 1'b0;
        step();
        step();
        check_eq("blank_legacy", {R_OUT, G_OUT, B_OUT}, 12'h000);
        BLANK = 1'b0;

        // long random run
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end
        async_reset();
        set_idle();
        for (int i = 0; i < 4; i++) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
